// File: rtl/pwm_peripheral_pkg.sv
// Shared constants and helpers for the 16-channel PWM peripheral.
// Counter width, output count and the default prescale ratio live here.
package pwm_peripheral_pkg;

  localparam int unsigned PWM_WIDTH       = 8;
  localparam int unsigned NUM_OUT         = 16;
  localparam int unsigned CLK_DIV_DEFAULT = 13;

  typedef logic [PWM_WIDTH-1:0] pwm_count_t;
  typedef logic [NUM_OUT-1:0]   pwm_vec_t;

  localparam pwm_count_t PWM_MAX = '1;

  // Full-scale duty forces a solid high so 255 never shows a one-step low.
  function automatic logic pwm_level_f(input pwm_count_t count, input pwm_count_t duty);
    return (duty == PWM_MAX) ? 1'b1 : (count < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk down to one step_tick every CLK_DIV cycles.
// With CLK_DIV==1 the counter stays at 0 and step_tick is constantly high.
module pwm_prescaler
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic step_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] presc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (presc_cnt == LAST) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + CW'(1);
    end
  end

  assign step_tick = (presc_cnt == LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: 8-bit step counter, shared duty, per-bit enable/mode mux.
// Define PWM_SHADOW_EN to latch the duty only at period boundaries.
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic       step_tick;
  logic       period_wrap;
  logic       pwm_level;
  pwm_count_t pwm_count;
  pwm_count_t duty_active;
  pwm_vec_t   en_out;
  pwm_vec_t   en_pwm;
  pwm_vec_t   out_next;

  pwm_prescaler #(
    .CLK_DIV   (CLK_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_tick (step_tick)
  );

  assign period_wrap = step_tick && (pwm_count == PWM_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_count    <= '0;
      period_start <= 1'b0;
    end else begin
      if (step_tick) begin
        pwm_count <= pwm_count + pwm_count_t'(1);
      end
      period_start <= period_wrap;
    end
  end

`ifdef PWM_SHADOW_EN
  // Duty is sampled on the wrap so every period runs with one consistent value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active <= '0;
    end else if (period_wrap) begin
      duty_active <= pwm_duty_cycle;
    end
  end
`else
  assign duty_active = pwm_duty_cycle;
`endif

  assign pwm_level = pwm_level_f(pwm_count, duty_active);

  assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign out_next = en_out & (~en_pwm | {NUM_OUT{pwm_level}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter: CLK_DIV, 13, system clocks per PWM step (legal range 1..65535).
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en_reg_out_7_0  input  8  output enable, bits 7:0.
REQ-005 Port: en_reg_out_15_8  input  8  output enable, bits 15:8.
REQ-006 Port: en_reg_pwm_7_0  input  8  PWM-mode select, bits 7:0.
REQ-007 Port: en_reg_pwm_15_8  input  8  PWM-mode select, bits 15:8.
REQ-008 Port: pwm_duty_cycle  input  8  requested duty, 0..255.
REQ-009 Port: out  output  16  registered drive outputs.
REQ-010 Port: period_start  output  1  one-cycle pulse at each PWM period start.
REQ-011 The block SHALL use one clock, clk, with an asynchronous active-low reset, rst_n; the register inputs are quasi-static values from the upstream SPI register stage, clk-synchronous, with no handshake.

Function
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; step_tick SHALL be asserted in the cycle where the prescaler equals CLK_DIV-1.
REQ-013 pwm_count (8 bits) SHALL increment on step_tick only and wrap 255->0; period length SHALL be exactly 256*CLK_DIV clocks.
REQ-014 period_start SHALL pulse high for exactly one clock, registered, in the cycle after step_tick moves pwm_count from 255 to 0.
REQ-015 pwm_level SHALL be 1 when duty_active==255, else (pwm_count < duty_active); duty 0 SHALL give constant 0 and duty 255 SHALL give constant 1 (no glitch).
REQ-016 For bit i: out[i] SHALL be 0 if enable bit i==0; 1 if enable==1 and PWM-mode bit i==0; pwm_level if both bits are 1.
REQ-017 out SHALL be registered, with one clock of latency from any enable/mode input change or pwm_level change to out.
REQ-018 High time per period SHALL be duty_active*CLK_DIV clocks for duty 0..254 and 256*CLK_DIV clocks for 255.
REQ-019 CLK_DIV==1 SHALL give step_tick every cycle, with prescaler held at 0.

Reset
REQ-020 While rst_n==0: prescaler=0, pwm_count=0, duty_active=0, out=16'h0000, period_start=0.
REQ-021 On rst_n release, counting SHALL start from 0 on the first clk edge; the first period_start SHALL follow after 256*CLK_DIV clocks.
REQ-022 Reset asserted mid-period SHALL abort the period immediately, with no partial pulse retained.

Configuration
REQ-023 Macro PWM_SHADOW_EN defined: duty_active SHALL load pwm_duty_cycle only on the step_tick that wraps pwm_count 255->0; a mid-period change SHALL take effect from the next period; after reset, the first period uses duty 0.
REQ-024 Macro PWM_SHADOW_EN undefined: duty_active SHALL track pwm_duty_cycle combinationally, taking effect in the same cycle; mid-period truncated or extended pulses are permitted.

Structure
REQ-025 A shared package SHALL hold the PWM_WIDTH=8 and NUM_OUT=16 constants and the default CLK_DIV constant.
REQ-026 The sub-module pwm_prescaler (prescaler counter plus step_tick) SHALL be instantiated once; per-bit output muxing SHALL stay in the top level.

Verification
REQ-027 Duty: CLK_DIV=13, all enable and PWM-mode bits=1, duty=128 -> each out bit high 1664 clocks and low 1664 clocks per 3328-clock period.
REQ-028 Extremes: duty=0 -> out=16'h0000 constantly; duty=255 -> out=16'hFFFF constantly, with no low cycle over 3 periods.
REQ-029 Mix: en_out_7_0=8'hFF, en_pwm_7_0=8'h0F, en_out_15_8=8'h00, duty=64 -> out[7:4]=1, out[3:0] high 832 of 3328 clocks, out[15:8]=0.
REQ-030 Shadow (PWM_SHADOW_EN): change duty 64->192 at pwm_count=100 -> current period high time stays 832 clocks, next period 2496; without the macro -> the edge moves in the same period.
REQ-031 Reset: assert rst_n=0 at pwm_count=50 -> out=0 and period_start=0 immediately; after release, period_start first pulses at clock 3328.
REQ-032 Latency: toggle en_reg_out_7_0[0] 0->1 with PWM-mode=0 -> out[0] rises exactly one clock later.
